// File: rtl/cpu_pkg.sv
// ============================================================================
// cpu_pkg : shared types and constants for the CPU host-side memory loader
// Revision : 1.0
// ============================================================================
`default_nettype none

package cpu_pkg;

  localparam int ADDR_STRIDE_DEF = 4;
  localparam int IMEM_DEPTH      = 512;
  localparam int DMEM_DEPTH      = 1024;
  localparam int CNT_W           = 11;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD_I    = 3'd1,
    ST_LOAD_D    = 3'd2,
    ST_RUN       = 3'd3,
    ST_DUMP_REQ  = 3'd4,
    ST_DUMP_WAIT = 3'd5,
    ST_DUMP_OUT  = 3'd6,
    ST_FIN       = 3'd7
  } loader_state_e;

  // Phase following cur, skipping every phase whose count is zero.
  function automatic loader_state_e next_phase(input loader_state_e cur, input logic i_nz,
                                               input logic d_nz, input logic r_nz,
                                               input logic u_nz);
    logic take_i, take_d, take_r, take_u;
    take_i = (cur == ST_IDLE) && i_nz;
    take_d = (cur inside {ST_IDLE, ST_LOAD_I}) && d_nz;
    take_r = (cur inside {ST_IDLE, ST_LOAD_I, ST_LOAD_D}) && r_nz;
    take_u = (cur inside {ST_IDLE, ST_LOAD_I, ST_LOAD_D, ST_RUN}) && u_nz;
    if (take_i)      return ST_LOAD_I;
    else if (take_d) return ST_LOAD_D;
    else if (take_r) return ST_RUN;
    else if (take_u) return ST_DUMP_REQ;
    else             return ST_FIN;
  endfunction

  function automatic logic [CNT_W-1:0] clamp_cnt(input logic [CNT_W-1:0] n, input int depth);
    return (n > CNT_W'(depth)) ? CNT_W'(depth) : n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/loader_counter.sv
// ============================================================================
// loader_counter : word counter with clear, increment and terminal-count flag
// Revision : 1.0
// ============================================================================
`default_nettype none

module loader_counter #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         arst_n,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] term,
  output logic [W-1:0] count,
  output logic         tc
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr)      count_d = '0;
    else if (inc) count_d = count_q + W'(1);
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) count_q <= '0;
    else         count_q <= count_d;
  end

  assign count = count_q;
  assign tc    = (count_q == term);

endmodule

`default_nettype wire

// File: rtl/reg_arstn_en.sv
// ============================================================================
// reg_arstn_en : enabled register with asynchronous active-low reset
// Revision : 1.0
// ============================================================================
`default_nettype none

module reg_arstn_en #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         arst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] val_q;
  logic [W-1:0] val_d;

  always_comb begin
    val_d = val_q;
    if (en) val_d = d;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) val_q <= '0;
    else         val_q <= val_d;
  end

  assign q = val_q;

endmodule

`default_nettype wire

// File: rtl/mem_loader.sv
// ============================================================================
// mem_loader : loads imem/dmem over the CPU ext ports, runs the CPU, dumps dmem
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_loader
  import cpu_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_STRIDE = ADDR_STRIDE_DEF,
  parameter int RD_LAT      = 1
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              start,
  input  logic [9:0]        imem_words,
  input  logic [10:0]       dmem_words,
  input  logic [31:0]       run_cycles,
  input  logic [31:0]       dump_base,
  input  logic [10:0]       dump_words,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              cpu_enable,
  output logic [31:0]       addr_ext,
  output logic              wen_ext,
  output logic              ren_ext,
  output logic [DATA_W-1:0] wdata_ext,
  output logic [31:0]       addr_ext_2,
  output logic              wen_ext_2,
  output logic              ren_ext_2,
  output logic [DATA_W-1:0] wdata_ext_2,
  input  logic [DATA_W-1:0] rdata_ext_2,
  output logic              busy,
  output logic              done
);

  localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  loader_state_e state_q, state_d;
  logic [31:0]      run_q, run_d;
  logic [LAT_W-1:0] wait_q, wait_d;

  logic             start_acc;
  logic [CNT_W-1:0] imem_in_c, dmem_in_c, dump_in_c;
  logic [CNT_W-1:0] imem_cnt_q, dmem_cnt_q, dump_cnt_q;
  logic [31:0]      dump_base_q;

  logic             cnt_clr, cnt_inc, cnt_tc, capture;
  logic [CNT_W-1:0] cnt, cnt_term;
  logic [31:0]      word_addr;
  logic             i_nz, d_nz, r_nz, u_nz;

  assign start_acc = (state_q == ST_IDLE) && start;
  assign imem_in_c = clamp_cnt({1'b0, imem_words}, IMEM_DEPTH);
  assign dmem_in_c = clamp_cnt(dmem_words, DMEM_DEPTH);
  assign dump_in_c = clamp_cnt(dump_words, DMEM_DEPTH);

  reg_arstn_en #(.W(CNT_W)) u_imem_cnt (.clk(clk), .arst_n(arst_n), .en(start_acc),
                                        .d(imem_in_c), .q(imem_cnt_q));
  reg_arstn_en #(.W(CNT_W)) u_dmem_cnt (.clk(clk), .arst_n(arst_n), .en(start_acc),
                                        .d(dmem_in_c), .q(dmem_cnt_q));
  reg_arstn_en #(.W(CNT_W)) u_dump_cnt (.clk(clk), .arst_n(arst_n), .en(start_acc),
                                        .d(dump_in_c), .q(dump_cnt_q));
  reg_arstn_en #(.W(32))    u_dump_base (.clk(clk), .arst_n(arst_n), .en(start_acc),
                                         .d(dump_base), .q(dump_base_q));
  reg_arstn_en #(.W(DATA_W)) u_out_data (.clk(clk), .arst_n(arst_n), .en(capture),
                                         .d(rdata_ext_2), .q(out_data));

  loader_counter #(.W(CNT_W)) u_word_cnt (
    .clk   (clk),
    .arst_n(arst_n),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .term  (cnt_term),
    .count (cnt),
    .tc    (cnt_tc)
  );

  assign word_addr = 32'(cnt) * 32'(ADDR_STRIDE);
  assign i_nz      = (imem_cnt_q != '0);
  assign d_nz      = (dmem_cnt_q != '0);
  assign r_nz      = (run_q != '0);
  assign u_nz      = (dump_cnt_q != '0);

  always_comb begin
    run_d = run_q;
    if (start_acc)               run_d = run_cycles;
    else if (state_q == ST_RUN)  run_d = run_q - 32'd1;

    wait_d = '0;
    if ((state_q == ST_DUMP_WAIT) && (wait_q != LAT_W'(RD_LAT - 1))) wait_d = wait_q + LAT_W'(1);
  end

  always_comb begin
    state_d     = state_q;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    cpu_enable  = 1'b0;
    addr_ext    = '0;
    wen_ext     = 1'b0;
    ren_ext     = 1'b0;
    wdata_ext   = '0;
    addr_ext_2  = '0;
    wen_ext_2   = 1'b0;
    ren_ext_2   = 1'b0;
    wdata_ext_2 = '0;
    cnt_clr     = 1'b0;
    cnt_inc     = 1'b0;
    cnt_term    = '0;
    capture     = 1'b0;
    busy        = (state_q != ST_IDLE);
    done        = (state_q == ST_FIN);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cnt_clr = 1'b1;
          state_d = next_phase(ST_IDLE, imem_in_c != '0, dmem_in_c != '0,
                               run_cycles != '0, dump_in_c != '0);
        end
      end
      ST_LOAD_I: begin
        in_ready = 1'b1;
        cnt_term = imem_cnt_q - CNT_W'(1);
        if (in_valid) begin
          wen_ext   = 1'b1;
          addr_ext  = word_addr;
          wdata_ext = in_data;
          if (cnt_tc) begin
            cnt_clr = 1'b1;
            state_d = next_phase(ST_LOAD_I, i_nz, d_nz, r_nz, u_nz);
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      ST_LOAD_D: begin
        in_ready = 1'b1;
        cnt_term = dmem_cnt_q - CNT_W'(1);
        if (in_valid) begin
          wen_ext_2   = 1'b1;
          addr_ext_2  = word_addr;
          wdata_ext_2 = in_data;
          if (cnt_tc) begin
            cnt_clr = 1'b1;
            state_d = next_phase(ST_LOAD_D, i_nz, d_nz, r_nz, u_nz);
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      ST_RUN: begin
        cpu_enable = 1'b1;
        if (run_q == 32'd1) state_d = next_phase(ST_RUN, i_nz, d_nz, r_nz, u_nz);
      end
      ST_DUMP_REQ: begin
        ren_ext_2  = 1'b1;
        addr_ext_2 = dump_base_q + word_addr;
        state_d    = ST_DUMP_WAIT;
      end
      ST_DUMP_WAIT: begin
        if (wait_q == LAT_W'(RD_LAT - 1)) begin
          capture = 1'b1;
          state_d = ST_DUMP_OUT;
        end
      end
      ST_DUMP_OUT: begin
        out_valid = 1'b1;
        cnt_term  = dump_cnt_q - CNT_W'(1);
        if (out_ready) begin
          if (cnt_tc) begin
            cnt_clr = 1'b1;
            state_d = ST_FIN;
          end else begin
            cnt_inc = 1'b1;
            state_d = ST_DUMP_REQ;
          end
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= ST_IDLE;
      run_q   <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      wait_q  <= wait_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_loader.sv
// ============================================================================
// tb_mem_loader : scoreboard bench for mem_loader with imem/dmem models
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mem_loader;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  imem_words = '0;
  logic [10:0] dmem_words = '0;
  logic [31:0] run_cycles = '0;
  logic [31:0] dump_base = '0;
  logic [10:0] dump_words = '0;
  logic        in_valid, in_ready, out_valid, out_ready, cpu_enable;
  logic [31:0] in_data, out_data;
  logic [31:0] addr_ext, wdata_ext, addr_ext_2, wdata_ext_2, rdata_ext_2;
  logic        wen_ext, ren_ext, wen_ext_2, ren_ext_2, busy, done;

  mem_loader dut (
    .clk(clk), .arst_n(arst_n), .start(start),
    .imem_words(imem_words), .dmem_words(dmem_words), .run_cycles(run_cycles),
    .dump_base(dump_base), .dump_words(dump_words),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .cpu_enable(cpu_enable),
    .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext), .wdata_ext(wdata_ext),
    .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
    .wdata_ext_2(wdata_ext_2), .rdata_ext_2(rdata_ext_2),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Memory models behind the ext ports; dmem read has one cycle of latency.
  logic [31:0] imem_m [0:511];
  logic [31:0] dmem_m [0:1023];
  always @(posedge clk) begin
    if (wen_ext)   imem_m[addr_ext[10:2]] <= wdata_ext;
    if (wen_ext_2) dmem_m[addr_ext_2[11:2]] <= wdata_ext_2;
    if (ren_ext_2) rdata_ext_2 <= dmem_m[addr_ext_2[11:2]];
  end

  logic [31:0] ref_imem [0:511];
  logic [31:0] ref_dmem [0:1023];
  logic [31:0] ld_q[$];
  logic [31:0] sb_q[$];

  typedef struct {
    int busy; int done; int cpu; int rise; int wi; int wd; int ren; int outs; int viol; int rdy;
  } stats_t;
  stats_t st = '{default: 0};

  int n_vec = 0;
  int n_err = 0;
  int tog_mode = 0;
  int stall = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h, required %0h", tag, act, exp);
    end
  endtask

  // Monitor samples at negedge, then drives the stream inputs just after posedge.
  initial begin
    logic        cpu_prev = 1'b0, held = 1'b0, tog = 1'b0;
    logic [31:0] held_data = '0;
    int          rdy_wait = 0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (busy) st.busy++;
      if (done) st.done++;
      if (in_ready) st.rdy++;
      if (cpu_enable) st.cpu++;
      if (cpu_enable && !cpu_prev) st.rise++;
      cpu_prev = cpu_enable;
      if (wen_ext) st.wi++;
      if (wen_ext_2) st.wd++;
      if (ren_ext_2) st.ren++;
      if (ren_ext || (wen_ext_2 && ren_ext_2) || ((wen_ext || wen_ext_2) && !in_valid) ||
          (cpu_enable && (wen_ext || wen_ext_2 || ren_ext_2)) || (ren_ext_2 && out_valid))
        st.viol++;
      if (in_valid && in_ready && ld_q.size() > 0) void'(ld_q.pop_front());
      if (out_valid) begin
        if (held && out_data !== held_data) st.viol++;
        if (out_ready) begin
          st.outs++;
          held = 1'b0;
          rdy_wait = 0;
          if (sb_q.size() == 0) chk("dump_extra", 1, 0);
          else chk("dump_word", out_data, sb_q.pop_front());
        end else begin
          held = 1'b1;
          held_data = out_data;
        end
      end else begin
        held = 1'b0;
      end
      @(posedge clk);
      #1;
      in_valid = (ld_q.size() > 0) && (tog_mode == 0 || tog);
      tog = ~tog;
      in_data = (ld_q.size() > 0) ? ld_q[0] : '0;
      if (out_valid) begin
        out_ready = (rdy_wait >= stall);
        rdy_wait++;
      end else begin
        out_ready = 1'b0;
        rdy_wait = 0;
      end
    end
  end

  task automatic do_start(input int ni, input int nd, input logic [31:0] nr,
                          input logic [31:0] base, input int nu, input int hold);
    @(posedge clk);
    #1;
    imem_words = 10'(ni);
    dmem_words = 11'(nd);
    run_cycles = nr;
    dump_base  = base;
    dump_words = 11'(nu);
    start = 1'b1;
    repeat (hold) @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int base_done, input int budget);
    int n = 0;
    while (st.done == base_done && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (st.done == base_done) chk("done_timeout", 0, 1);
    @(posedge clk);
    #1;
    chk("busy_after_done", busy, 0);
  endtask

  task automatic run_seq(input int ni, input int nd, input logic [31:0] nr,
                         input logic [31:0] base, input int nu);
    stats_t s0;
    logic [31:0] w;
    s0 = st;
    for (int i = 0; i < ni; i++) begin
      w = $urandom; ref_imem[i] = w; ld_q.push_back(w);
    end
    for (int i = 0; i < nd; i++) begin
      w = $urandom; ref_dmem[i] = w; ld_q.push_back(w);
    end
    for (int k = 0; k < nu; k++) sb_q.push_back(ref_dmem[(base >> 2) + k]);
    do_start(ni, nd, nr, base, nu, 1);
    wait_done(s0.done, 5000);
    for (int i = 0; i < ni; i++) chk("imem_word", imem_m[i], ref_imem[i]);
    for (int i = 0; i < nd; i++) chk("dmem_word", dmem_m[i], ref_dmem[i]);
    chk("imem_writes", st.wi - s0.wi, ni);
    chk("dmem_writes", st.wd - s0.wd, nd);
    chk("run_cycles", st.cpu - s0.cpu, nr);
    chk("run_bursts", st.rise - s0.rise, (nr != 0) ? 1 : 0);
    chk("read_pulses", st.ren - s0.ren, nu);
    chk("dump_count", st.outs - s0.outs, nu);
    chk("done_pulses", st.done - s0.done, 1);
    chk("protocol_viol", st.viol - s0.viol, 0);
    chk("sb_left", sb_q.size(), 0);
    chk("ld_left", ld_q.size(), 0);
  endtask

  initial begin
    stats_t s0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_outs", {busy, done, in_ready, out_valid, cpu_enable, wen_ext, ren_ext,
                       wen_ext_2, ren_ext_2, |addr_ext, |addr_ext_2, |out_data}, 0);
    @(posedge clk);
    #1;
    arst_n = 1'b1;

    // basic load, no run, no dump
    run_seq(3, 2, 0, 0, 0);

    // in_valid gaps during imem load
    tog_mode = 1;
    run_seq(4, 0, 0, 0, 0);
    tog_mode = 0;

    // run window then single-word dump
    run_seq(1, 1, 5, 0, 1);

    // dump window at 0x10 with slow consumer
    stall = 4;
    run_seq(0, 8, 2, 32'h10, 3);
    stall = 0;

    // all counts zero, start held into FIN
    s0 = st;
    do_start(0, 0, 0, 0, 0, 2);
    repeat (4) @(posedge clk);
    chk("zero_busy_cycles", st.busy - s0.busy, 1);
    chk("zero_done", st.done - s0.done, 1);
    chk("zero_enables", (st.wi - s0.wi) + (st.wd - s0.wd) + (st.ren - s0.ren) + (st.cpu - s0.cpu), 0);

    // start while busy is ignored; latched counts survive input changes
    s0 = st;
    do_start(0, 0, 20, 0, 0, 1);
    repeat (3) @(posedge clk);
    do_start(2, 0, 3, 0, 0, 1);
    wait_done(s0.done, 200);
    chk("busy_start_run", st.cpu - s0.cpu, 20);
    chk("busy_start_ready", st.rdy - s0.rdy, 0);
    chk("busy_start_done", st.done - s0.done, 1);

    // asynchronous reset in RUN
    do_start(0, 0, 1000, 0, 0, 1);
    repeat (10) @(posedge clk);
    #1;
    chk("run_active", cpu_enable, 1);
    #2;
    arst_n = 1'b0;
    #1;
    chk("arst_cpu_enable", cpu_enable, 0);
    chk("arst_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1;
    arst_n = 1'b1;
    run_seq(2, 2, 3, 0, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
